// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit add via one reused 2-bit slice, LSB first; define SERIAL_ADD_SUB_EN for a - b
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/2 - 1);
  if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be even and >= 2");
  end
  state_t           state, nxt;
  logic [WIDTH-1:0] a_r, b_r, b_ld;
  logic             carry, c_ld, last;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       s2;
`ifdef SERIAL_ADD_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | c_in;
`else
  assign b_ld = b;
  assign c_ld = c_in;
`endif
  assign s2    = {1'b0, a_r[1:0]} + {1'b0, b_r[1:0]} + {2'b0, carry};
  assign last  = cnt == LAST;
  assign ready = state == IDLE;
  assign busy  = state == RUN;
  assign done  = state == DONE;
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (ready && start) begin
      a_r   <= a;
      b_r   <= b_ld;
      carry <= c_ld;
      cnt   <= '0;
    end else if (busy) begin
      sum   <= {s2[1:0], sum[WIDTH-1:2]};
      carry <= s2[2];
      a_r   <= a_r >> 2;
      b_r   <= b_r >> 2;
      cnt   <= cnt + 1'b1;
      if (last) c_out <= s2[2];
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl against an arithmetic reference
module tb_serial_add_ctrl;
  logic       clk, rst, start, c_in, ready, busy, done, c_out;
  logic [7:0] a, b, sum, prev_sum;
  logic       prev_cout;
  int         tests, fails;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
`endif
  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .a(a), .b(b), .c_in(c_in), .ready(ready), .busy(busy), .done(done),
    .sum(sum), .c_out(c_out)
  );
  always #5 clk = ~clk;
  task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic ci, input logic si, input string name);
    logic [8:0] exp;
    int nbusy, guard;
    exp = {1'b0, ai} + {1'b0, (si ? ~bi : bi)} + 9'(si | ci);
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL %s ready_before got=%b want=1", name, ready); end
    start = 1; a = ai; b = bi; c_in = ci;
`ifdef SERIAL_ADD_SUB_EN
    sub = si;
`endif
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'($urandom);
`endif
    tests++;
    if (busy !== 1'b1 || sum !== prev_sum || c_out !== prev_cout) begin
      fails++; $display("FAIL %s held_at_accept busy=%b sum=%h c_out=%b want busy=1 sum=%h c_out=%b", name, busy, sum, c_out, prev_sum, prev_cout);
    end
    nbusy = 0; guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      tests++;
      if ($countones({ready, busy, done}) != 1) begin fails++; $display("FAIL %s exclusive ready=%b busy=%b done=%b", name, ready, busy, done); end
      if (busy === 1'b1) nbusy++;
      start = 1'($urandom);
      @(negedge clk);
      guard++;
    end
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL %s timeout waiting for done", name); start = 0; return; end
    start = 0;
    tests++;
    if (nbusy != 4) begin fails++; $display("FAIL %s busy_cycles got=%0d want=4", name, nbusy); end
    tests++;
    if ({c_out, sum} !== exp) begin fails++; $display("FAIL %s result got c_out=%b sum=%h want c_out=%b sum=%h", name, c_out, sum, exp[8], exp[7:0]); end
    @(negedge clk);
    tests++;
    if (ready !== 1'b1 || done !== 1'b0 || {c_out, sum} !== exp) begin
      fails++; $display("FAIL %s after_done ready=%b done=%b sum=%h c_out=%b want ready=1 done=0 sum=%h c_out=%b", name, ready, done, sum, c_out, exp[7:0], exp[8]);
    end
    prev_sum = exp[7:0]; prev_cout = exp[8];
  endtask
  task automatic test_reset;
    rst = 1; start = 0; a = 0; b = 0; c_in = 0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 0;
`endif
    repeat (2) @(negedge clk);
    tests++;
    if (ready !== 1 || busy !== 0 || done !== 0 || sum !== 0 || c_out !== 0) begin
      fails++; $display("FAIL reset ready=%b busy=%b done=%b sum=%h c_out=%b want 1 0 0 00 0", ready, busy, done, sum, c_out);
    end
    rst = 0;
    prev_sum = 0; prev_cout = 0;
  endtask
  task automatic test_directed;
    do_op(8'h5A, 8'h33, 0, 0, "plan1");
    do_op(8'hFF, 8'h01, 0, 0, "wrap_ff_01");
    do_op(8'hFF, 8'h00, 1, 0, "ripple_cin");
    do_op(8'h00, 8'h00, 0, 0, "zero");
  endtask
  task automatic test_hold_start;
    int last_cyc, ndone;
    last_cyc = -1; ndone = 0;
    start = 1; a = 8'h01; b = 8'h02; c_in = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        tests++;
        if (sum !== 8'h03 || c_out !== 1'b0) begin fails++; $display("FAIL hold_result got sum=%h c_out=%b want 03 0", sum, c_out); end
        if (last_cyc >= 0) begin
          tests++;
          if (i - last_cyc != 6) begin fails++; $display("FAIL hold_period got=%0d want=6", i - last_cyc); end
        end
        last_cyc = i; ndone++;
      end
      if (busy === 1'b1) begin a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom); end
      else begin a = 8'h01; b = 8'h02; c_in = 0; end
    end
    start = 0;
    tests++;
    if (ndone < 4) begin fails++; $display("FAIL hold_count got=%0d want>=4", ndone); end
    for (int i = 0; i < 10 && ready !== 1'b1; i++) @(negedge clk);
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL hold_drain timeout ready=%b", ready); end
    prev_sum = 8'h03; prev_cout = 0;
  endtask
  task automatic test_reset_mid_run;
    bit saw_done;
    start = 1; a = 8'hAA; b = 8'h55; c_in = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    tests++;
    if (ready !== 1 || busy !== 0 || done !== 0 || sum !== 0 || c_out !== 0) begin
      fails++; $display("FAIL midrun_reset ready=%b busy=%b done=%b sum=%h c_out=%b want 1 0 0 00 0", ready, busy, done, sum, c_out);
    end
    saw_done = 0;
    repeat (6) begin @(negedge clk); if (done !== 1'b0) saw_done = 1; end
    tests++;
    if (saw_done) begin fails++; $display("FAIL midrun_no_done got done pulse want none"); end
    prev_sum = 0; prev_cout = 0;
    do_op(8'h0F, 8'h01, 0, 0, "after_abort");
  endtask
  task automatic test_back_to_back;
    do_op(8'h80, 8'h80, 0, 0, "b2b_first");
    do_op(8'h01, 8'h01, 0, 0, "b2b_second");
  endtask
  task automatic test_random;
    logic si;
    for (int i = 0; i < 24; i++) begin
`ifdef SERIAL_ADD_SUB_EN
      si = 1'($urandom);
`else
      si = 0;
`endif
      do_op(8'($urandom), 8'($urandom), 1'($urandom), si, "random");
    end
  endtask
`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    do_op(8'h10, 8'h01, 0, 1, "sub_10_01");
    do_op(8'h00, 8'h01, 0, 1, "sub_borrow");
    do_op(8'h10, 8'h01, 1, 0, "sub_off");
  endtask
`endif
  initial begin
    clk = 0; tests = 0; fails = 0;
    test_reset;
    test_directed;
    test_hold_start;
    test_reset_mid_run;
    test_back_to_back;
`ifdef SERIAL_ADD_SUB_EN
    test_sub;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
